pixel_sequencer: RTL

Parametrised successor to the single-frame pixel FSM. Sequences one global-shutter frame (erase -> expose -> convert -> row-by-row readout) for an array of N_ROWS readout groups. Adds a runtime exposure length, start/busy/frame_done handshake, continuous (free-running) mode, synchronous abort, and an on-chip ADC ramp code. Sits between the camera control logic and the pixel array / ADC ramp.

---
 rtl/pixel_seq_pkg.sv | 24 ++
 rtl/pixel_phase_timer.sv | 25 ++
 rtl/pixel_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pixel_seq_pkg.sv
// rtl/pixel_seq_pkg.sv - shared state type, default phase lengths and width helper for the pixel sequencer
package pixel_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        DONE
    } seq_state_t;

    localparam int DEF_N_ROWS    = 2;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_C_ERASE   = 5;
    localparam int DEF_C_CONVERT = 255;
    localparam int DEF_C_READ    = 5;

    // A single readout group still needs a 1-bit row_idx port.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// rtl/pixel_phase_timer.sv - shared phase counter with clear/enable and terminal-count compare
module pixel_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // A phase of length L ends on its last cycle, count == L-1.
    assign tc = (count == len - CNT_W'(1));

endmodule

// File: rtl/pixel_sequencer.sv
// rtl/pixel_sequencer.sv - global-shutter frame sequencer: erase, expose, convert, row readout
module pixel_sequencer
    import pixel_seq_pkg::*;
#(
    parameter int N_ROWS    = DEF_N_ROWS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int C_ERASE   = DEF_C_ERASE,
    parameter int C_CONVERT = DEF_C_CONVERT,
    parameter int C_READ    = DEF_C_READ
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      continuous,
    input  logic                      abort,
    input  logic [CNT_W-1:0]          expose_len,
    output logic                      erase,
    output logic                      expose,
    output logic                      convert,
    output logic [N_ROWS-1:0]         read,
    output logic [row_w(N_ROWS)-1:0]  row_idx,
    output logic [CNT_W-1:0]          ramp_code,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int RW = row_w(N_ROWS);

    seq_state_t       state;
    logic [RW-1:0]    row;
    logic [RW-1:0]    row_inc;
    logic [CNT_W-1:0] exp_len_q;
    logic [CNT_W-1:0] exp_len_in;
    logic [CNT_W-1:0] phase_len;
    logic [CNT_W-1:0] count;
    logic             tc;
    logic             clear;

    assign exp_len_in = (expose_len == '0) ? CNT_W'(1) : expose_len;
    assign row_inc    = row + RW'(1);

    // Counter restarts on every state or row change, and is held at 0 outside the timed phases.
    assign clear = (state == IDLE) || (state == DONE) || tc || abort;

    always_comb begin
        phase_len = CNT_W'(1);
        case (state)
            ERASE:   phase_len = CNT_W'(C_ERASE);
            EXPOSE:  phase_len = exp_len_q;
            CONVERT: phase_len = CNT_W'(C_CONVERT);
            READ:    phase_len = CNT_W'(C_READ);
            default: phase_len = CNT_W'(1);
        endcase
    end

    pixel_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (state != IDLE),
        .len    (phase_len),
        .count  (count),
        .tc     (tc)
    );

    // Outputs are decoded from the state being entered so they line up with that state's cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            exp_len_q  <= CNT_W'(1);
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= '0;
            row_idx    <= '0;
            ramp_code  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= '0;
            row_idx    <= '0;
            ramp_code  <= '0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                row   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= ERASE;
                            exp_len_q <= exp_len_in;
                            erase     <= 1'b1;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    ERASE: begin
                        if (tc) begin
                            state  <= EXPOSE;
                            expose <= 1'b1;
                        end else begin
                            erase <= 1'b1;
                        end
                    end
                    EXPOSE: begin
                        state   <= tc ? CONVERT : EXPOSE;
                        expose  <= !tc;
                        convert <= tc;
                    end
                    CONVERT: begin
                        if (tc) begin
                            state <= READ;
                            row   <= '0;
                            read  <= N_ROWS'(1);
                        end else begin
                            convert   <= 1'b1;
                            ramp_code <= count + CNT_W'(1);
                        end
                    end
                    READ: begin
                        if (!tc) begin
                            read    <= N_ROWS'(1) << row;
                            row_idx <= row;
                        end else if (row == RW'(N_ROWS - 1)) begin
                            state      <= DONE;
                            row        <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row     <= row_inc;
                            read    <= N_ROWS'(1) << row_inc;
                            row_idx <= row_inc;
                        end
                    end
                    DONE: begin
                        if (continuous) begin
                            state     <= ERASE;
                            exp_len_q <= exp_len_in;
                            erase     <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
